// File: rtl/sram_multi_fifo_if.sv
// Channel handshakes and SRAM pins of the multi-channel SRAM FIFO.
// master: client/board side; slave: the FIFO controller.
interface sram_multi_fifo_if #(
  parameter int NCH = 2,
  parameter int AW  = 18,
  parameter int DW  = 16,
  parameter int D   = 16
);
  logic [NCH-1:0]       wr_req;
  logic [NCH*DW-1:0]    wr_data;
  logic [NCH-1:0]       wr_ack;
  logic [NCH-1:0]       rd_req;
  logic [NCH*DW-1:0]    rd_data;
  logic [NCH-1:0]       rd_valid;
  logic [NCH-1:0]       pkt_start;
  logic [NCH-1:0]       pkt_end;
  logic [NCH-1:0]       pkt_abort;
  logic [NCH-1:0]       full;
  logic [NCH-1:0]       afull;
  logic [NCH-1:0]       empty;
  logic [NCH*(D+1)-1:0] used;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        dq_o;
  logic                 dq_oe;
  logic [DW-1:0]        dq_i;
  logic                 CE_n;
  logic                 OE_n;
  logic                 WE_n;
  logic                 LB_n;
  logic                 UB_n;

  modport master (
    output wr_req, wr_data, rd_req,
    output pkt_start, pkt_end, pkt_abort,
    output dq_i,
    input  wr_ack, rd_data, rd_valid,
    input  full, afull, empty, used,
    input  mem_addr, dq_o, dq_oe,
    input  CE_n, OE_n, WE_n, LB_n, UB_n
  );

  modport slave (
    input  wr_req, wr_data, rd_req,
    input  pkt_start, pkt_end, pkt_abort,
    input  dq_i,
    output wr_ack, rd_data, rd_valid,
    output full, afull, empty, used,
    output mem_addr, dq_o, dq_oe,
    output CE_n, OE_n, WE_n, LB_n, UB_n
  );
endinterface

// File: rtl/sram_multi_fifo.sv
// NCH ring-buffer FIFOs with packet rollback on one single-port SRAM.
// Ports: clk, rst_n (async low), bus (channel handshakes + SRAM pins).
module sram_multi_fifo #(
  parameter int NCH          = 2,
  parameter int AW           = 18,
  parameter int DW           = 16,
  parameter int D            = 16,
  parameter int AFULL_MARGIN = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  sram_multi_fifo_if.slave bus
);
  localparam int NR = 2 * NCH;
  localparam int RW = $clog2(NR);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [D:0] DEPTH = {1'b1, {D{1'b0}}};

  typedef enum logic [1:0] {
    IDLE, SETUP, STROBE, FINISH
  } state_t;

  state_t state;

  logic [D-1:0]  wr_ptr [NCH];
  logic [D-1:0]  rd_ptr [NCH];
  logic [D-1:0]  mark   [NCH];
  logic [D:0]    used_q [NCH];
  logic [DW-1:0] rdat   [NCH];
  logic [NCH-1:0] open_q;
  logic [NCH-1:0] ack_q, vld_q;
  logic [NCH-1:0] full_q, afull_q, empty_q;

  logic [RW-1:0] rr;
  logic          gwr;
  logic [CW-1:0] gch;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] dqo_q;
  logic oe_q, ce_n_q, oe_n_q, we_n_q, bn_q;

  logic [D-1:0] wp_n [NCH];
  logic [D-1:0] rp_n [NCH];
  logic [D-1:0] mk_n [NCH];
  logic [D:0]   u_n  [NCH];
  logic [D:0]   av_n [NCH];
  logic [NCH-1:0] op_n, full_n, afull_n, empty_n;
  logic [NR-1:0]  elig;

  logic fin;
  assign fin = (state == FINISH);

  // Next channel state: the finishing access first,
  // then this cycle's packet control on top of it.
  always_comb begin
    logic w, r;
    logic [D-1:0] pend;
    w = 1'b0;
    r = 1'b0;
    pend = '0;
    elig = '0;
    for (int c = 0; c < NCH; c++) begin
      w = fin && gwr && (int'(gch) == c);
      r = fin && !gwr && (int'(gch) == c);
      wp_n[c] = wr_ptr[c] + D'(w);
      rp_n[c] = rd_ptr[c] + D'(r);
      u_n[c]  = used_q[c] + {{D{1'b0}}, w}
              - {{D{1'b0}}, r};
      mk_n[c] = mark[c];
      op_n[c] = open_q[c];
      if (bus.pkt_abort[c]) begin
        if (open_q[c]) begin
          pend    = wp_n[c] - mk_n[c];
          u_n[c]  = u_n[c] - {1'b0, pend};
          wp_n[c] = mk_n[c];
          op_n[c] = 1'b0;
        end
      end else if (bus.pkt_end[c]) begin
        op_n[c] = 1'b0;
      end else if (bus.pkt_start[c]) begin
        mk_n[c] = wp_n[c];
        op_n[c] = 1'b1;
      end
      pend = op_n[c] ? (wp_n[c] - mk_n[c]) : '0;
      av_n[c]    = u_n[c] - {1'b0, pend};
      full_n[c]  = (u_n[c] == DEPTH);
      afull_n[c] = (32'(DEPTH) - 32'(u_n[c]))
                   <= 32'(AFULL_MARGIN);
      empty_n[c] = (av_n[c] == '0);
      elig[2*c]   = bus.wr_req[c] && !full_n[c];
      elig[2*c+1] = bus.rd_req[c] && !empty_n[c];
    end
  end

  logic          any;
  logic [RW-1:0] pick;

  always_comb begin
    int idx;
    idx  = 0;
    any  = 1'b0;
    pick = '0;
    for (int i = 0; i < NR; i++) begin
      idx = int'(rr) + i;
      if (idx >= NR) idx = idx - NR;
      if (!any && elig[idx]) begin
        any  = 1'b1;
        pick = RW'(idx);
      end
    end
  end

  logic          go, pwr;
  logic [CW-1:0] pch;
  assign go  = (state == IDLE || fin) && any;
  assign pwr = ~pick[0];
  assign pch = CW'(pick >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr      <= '0;
      gwr     <= 1'b0;
      gch     <= '0;
      addr_q  <= '0;
      dqo_q   <= '0;
      oe_q    <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      bn_q    <= 1'b1;
      ack_q   <= '0;
      vld_q   <= '0;
      open_q  <= '0;
      full_q  <= '0;
      afull_q <= '0;
      empty_q <= '1;
      for (int c = 0; c < NCH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        mark[c]   <= '0;
        used_q[c] <= '0;
        rdat[c]   <= '0;
      end
    end else begin
      ack_q   <= '0;
      vld_q   <= '0;
      open_q  <= op_n;
      full_q  <= full_n;
      afull_q <= afull_n;
      empty_q <= empty_n;
      for (int c = 0; c < NCH; c++) begin
        wr_ptr[c] <= wp_n[c];
        rd_ptr[c] <= rp_n[c];
        mark[c]   <= mk_n[c];
        used_q[c] <= u_n[c];
      end
      if (go) begin
        state  <= SETUP;
        gwr    <= pwr;
        gch    <= pch;
        rr     <= (int'(pick) == NR - 1) ?
                  '0 : pick + RW'(1);
        ce_n_q <= 1'b0;
        bn_q   <= 1'b0;
        oe_q   <= pwr;
        if (pwr)
          dqo_q <= bus.wr_data[int'(pch)*DW +: DW];
        addr_q <= (AW'(pch) << D) |
                  AW'(pwr ? wp_n[pch] : rp_n[pch]);
      end else begin
        unique case (state)
          IDLE: ;
          SETUP: begin
            state <= STROBE;
            if (gwr) we_n_q <= 1'b0;
            else     oe_n_q <= 1'b0;
          end
          STROBE: begin
            state  <= FINISH;
            we_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            ce_n_q <= 1'b1;
            bn_q   <= 1'b1;
            if (gwr) begin
              ack_q[gch] <= 1'b1;
            end else begin
              vld_q[gch] <= 1'b1;
              rdat[gch]  <= bus.dq_i;
            end
          end
          FINISH: begin
            state <= IDLE;
            oe_q  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    bus.wr_ack   = ack_q;
    bus.rd_valid = vld_q;
    bus.full     = full_q;
    bus.afull    = afull_q;
    bus.empty    = empty_q;
    bus.used     = '0;
    bus.rd_data  = '0;
    for (int c = 0; c < NCH; c++) begin
      bus.used[c*(D+1) +: D+1] = used_q[c];
      bus.rd_data[c*DW +: DW]  = rdat[c];
    end
    bus.mem_addr = addr_q;
    bus.dq_o     = dqo_q;
    bus.dq_oe    = oe_q;
    bus.CE_n     = ce_n_q;
    bus.OE_n     = oe_n_q;
    bus.WE_n     = we_n_q;
    bus.LB_n     = bn_q;
    bus.UB_n     = bn_q;
  end
endmodule

// File: tb/tb_sram_multi_fifo.sv
// Bench for sram_multi_fifo: vector table, corner sequences,
// random traffic against a queue-based FIFO/packet model.
module tb_sram_multi_fifo;
  localparam int NCH = 2;
  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int D   = 4;
  localparam int AFM = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_multi_fifo_if #(.NCH(NCH), .AW(AW), .DW(DW), .D(D)) bus();

  sram_multi_fifo #(
    .NCH(NCH), .AW(AW), .DW(DW), .D(D), .AFULL_MARGIN(AFM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  bit [15:0] sram [0:(1<<AW)-1];

  always @(posedge clk)
    if (!bus.CE_n && !bus.WE_n && bus.dq_oe)
      sram[bus.mem_addr] <= bus.dq_o;

  always_comb begin
    bus.dq_i = 16'hDEAD;
    if (!bus.CE_n && !bus.OE_n) bus.dq_i = sram[bus.mem_addr];
  end

  // reference model: visible words, open-packet words
  logic [15:0] com_q [NCH][$];
  logic [15:0] pend_q [NCH][$];
  bit pk_open [NCH];

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [31:0] got,
                       logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int m_used(int c);
    return com_q[c].size() + pend_q[c].size();
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    bus.wr_req = '0;
    bus.rd_req = '0;
    bus.pkt_start = '0;
    bus.pkt_end = '0;
    bus.pkt_abort = '0;
    bus.wr_data = '0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    for (int c = 0; c < NCH; c++) begin
      com_q[c].delete();
      pend_q[c].delete();
      pk_open[c] = 1'b0;
    end
  endtask

  task automatic do_write(int c, logic [15:0] d, int lim,
                          output bit got, output int n);
    bus.wr_data[c*DW +: DW] = d;
    bus.wr_req[c] = 1'b1;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < lim && !got; i++) begin
      tick;
      n++;
      if (bus.wr_ack[c]) got = 1'b1;
    end
    bus.wr_req[c] = 1'b0;
    if (got) begin
      if (pk_open[c]) pend_q[c].push_back(d);
      else com_q[c].push_back(d);
    end
  endtask

  task automatic do_read(int c, int lim, output bit got,
                         output logic [15:0] d);
    bus.rd_req[c] = 1'b1;
    got = 1'b0;
    d = '0;
    for (int i = 0; i < lim && !got; i++) begin
      tick;
      if (bus.rd_valid[c]) begin
        got = 1'b1;
        d = bus.rd_data[c*DW +: DW];
      end
    end
    bus.rd_req[c] = 1'b0;
  endtask

  // kind: 0 start, 1 end, 2 abort
  task automatic pkt(int kind, int c);
    if (kind == 0) bus.pkt_start[c] = 1'b1;
    if (kind == 1) bus.pkt_end[c] = 1'b1;
    if (kind == 2) bus.pkt_abort[c] = 1'b1;
    tick;
    bus.pkt_start[c] = 1'b0;
    bus.pkt_end[c] = 1'b0;
    bus.pkt_abort[c] = 1'b0;
    if (pk_open[c] && kind != 2)
      while (pend_q[c].size() > 0)
        com_q[c].push_back(pend_q[c].pop_front());
    if (kind == 2) pend_q[c].delete();
    pk_open[c] = (kind == 0);
  endtask

  task automatic chk_state(string tag, int c);
    int u;
    u = m_used(c);
    check({tag, "_used"}, 32'(bus.used[c*(D+1) +: D+1]), u);
    check({tag, "_empty"}, 32'(bus.empty[c]),
          32'(com_q[c].size() == 0));
    check({tag, "_full"}, 32'(bus.full[c]), 32'(u == DEPTH));
    check({tag, "_afull"}, 32'(bus.afull[c]),
          32'((DEPTH - u) <= AFM));
  endtask

  task automatic wr_chk(string tag, int c, logic [15:0] d);
    bit exp_ack, got;
    int n;
    exp_ack = (m_used(c) < DEPTH);
    do_write(c, d, exp_ack ? 20 : 8, got, n);
    check({tag, "_ack"}, 32'(got), 32'(exp_ack));
  endtask

  task automatic rd_chk(string tag, int c);
    bit got;
    logic [15:0] d, e;
    if (com_q[c].size() == 0) begin
      do_read(c, 8, got, d);
      check({tag, "_novalid"}, 32'(got), 0);
    end else begin
      e = com_q[c].pop_front();
      do_read(c, 20, got, d);
      check({tag, "_valid"}, 32'(got), 1);
      check({tag, "_data"}, 32'(d), 32'(e));
    end
  endtask

  // op: 0 write, 1 read (data = expected), 2 read expecting none,
  //     3 pkt_start, 4 pkt_end, 5 pkt_abort
  typedef struct {
    int          op;
    int          ch;
    logic [15:0] data;
    int          eused;
    bit          eempty;
  } vec_t;

  vec_t tbl [21];

  initial begin
    bit got;
    int n;
    logic [15:0] d;
    int ack_ch [4];
    int ack_t [4];

    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    int n, cnt, cyc;
    logic [15:0] d;
    int ack_ch [4];
    int ack_t [4];

    tbl[0]  = '{0, 0, 16'hA000, 1, 1'b0};
    tbl[1]  = '{0, 0, 16'hA001, 2, 1'b0};
    tbl[2]  = '{0, 0, 16'hA002, 3, 1'b0};
    tbl[3]  = '{3, 0, 16'h0000, 3, 1'b0};
    tbl[4]  = '{0, 0, 16'hB000, 4, 1'b0};
    tbl[5]  = '{0, 0, 16'hB001, 5, 1'b0};
    tbl[6]  = '{0, 0, 16'hB002, 6, 1'b0};
    tbl[7]  = '{0, 0, 16'hB003, 7, 1'b0};
    tbl[8]  = '{0, 0, 16'hB004, 8, 1'b0};
    tbl[9]  = '{1, 0, 16'hA000, 7, 1'b0};
    tbl[10] = '{1, 0, 16'hA001, 6, 1'b0};
    tbl[11] = '{1, 0, 16'hA002, 5, 1'b1};
    tbl[12] = '{2, 0, 16'h0000, 5, 1'b1};
    tbl[13] = '{5, 0, 16'h0000, 0, 1'b1};
    tbl[14] = '{3, 0, 16'h0000, 0, 1'b1};
    tbl[15] = '{0, 0, 16'hC000, 1, 1'b1};
    tbl[16] = '{0, 0, 16'hC001, 2, 1'b1};
    tbl[17] = '{4, 0, 16'h0000, 2, 1'b0};
    tbl[18] = '{1, 0, 16'hC000, 1, 1'b0};
    tbl[19] = '{1, 0, 16'hC001, 0, 1'b1};
    tbl[20] = '{2, 1, 16'h0000, 0, 1'b1};

    // reset state
    do_reset;
    check("rst_strobes", 32'({bus.CE_n, bus.OE_n, bus.WE_n,
                              bus.LB_n, bus.UB_n}), 32'h1f);
    check("rst_dq_oe", 32'(bus.dq_oe), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_empty", 32'(bus.empty), 32'h3);
    check("rst_full", 32'(bus.full), 0);
    check("rst_afull", 32'(bus.afull), 0);
    check("rst_used", 32'(bus.used), 0);
    check("rst_ack", 32'({bus.wr_ack, bus.rd_valid}), 0);

    // rollback vectors
    for (int i = 0; i < 21; i++) begin
      vec_t v;
      v = tbl[i];
      case (v.op)
        0: begin
          do_write(v.ch, v.data, 20, got, n);
          check($sformatf("vec%0d_ack", i), 32'(got), 1);
          tick;
        end
        1: begin
          do_read(v.ch, 20, got, d);
          check($sformatf("vec%0d_valid", i), 32'(got), 1);
          check($sformatf("vec%0d_data", i), 32'(d), 32'(v.data));
          tick;
        end
        2: begin
          do_read(v.ch, 8, got, d);
          check($sformatf("vec%0d_novalid", i), 32'(got), 0);
        end
        default: pkt(v.op - 3, v.ch);
      endcase
      check($sformatf("vec%0d_used", i),
            32'(bus.used[v.ch*(D+1) +: D+1]), v.eused);
      check($sformatf("vec%0d_empty", i),
            32'(bus.empty[v.ch]), 32'(v.eempty));
    end

    // fill ch0 to full, overflow attempt, drain
    do_reset;
    for (int i = 0; i < DEPTH; i++) begin
      do_write(0, 16'h1000 + 16'(i), 20, got, n);
      check($sformatf("fill%0d_ack", i), 32'(got), 1);
      if (i == 0) check("fill_latency", n, 3);
      tick;
      if (i == 10) check("afull_below", 32'(bus.afull[0]), 0);
      if (i == 11) check("afull_at", 32'(bus.afull[0]), 1);
    end
    check("full_set", 32'(bus.full[0]), 1);
    do_write(0, 16'h1FFF, 10, got, n);
    check("overflow_noack", 32'(got), 0);
    check("overflow_used", 32'(bus.used[D:0]), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      do_read(0, 20, got, d);
      check($sformatf("drain%0d", i), 32'(d), 32'h1000 + i);
      tick;
    end
    check("drain_empty", 32'(bus.empty), 32'h3);
    check("drain_full", 32'(bus.full[0]), 0);

    // wrap on ch1
    do_reset;
    for (int i = 0; i < 10; i++) begin
      do_write(1, 16'h0100 + 16'(i), 20, got, n);
      tick;
    end
    for (int i = 0; i < 10; i++) begin
      do_read(1, 20, got, d);
      check($sformatf("wrapa%0d", i), 32'(d), 32'h0100 + i);
      tick;
    end
    for (int i = 0; i < 10; i++) begin
      do_write(1, 16'h2000 + 16'(i), 20, got, n);
      tick;
    end
    check("wrap_used", 32'(bus.used[2*D+1:D+1]), 10);
    check("wrap_last_addr", 32'(sram[16 + (19 % 16)]), 32'h2009);
    check("wrap_top_addr", 32'(sram[16 + 15]), 32'h2005);
    for (int i = 0; i < 10; i++) begin
      do_read(1, 20, got, d);
      check($sformatf("wrapb%0d", i), 32'(d), 32'h2000 + i);
      tick;
    end
    check("wrap_empty", 32'(bus.empty[1]), 1);

    // fairness with both write requests held
    do_reset;
    bus.wr_data = {16'h5101, 16'h5000};
    bus.wr_req = 2'b11;
    cnt = 0;
    for (cyc = 1; cyc <= 40 && cnt < 4; cyc++) begin
      tick;
      if (bus.wr_ack != 0) begin
        check("fair_onehot", 32'(bus.wr_ack == 2'b11), 0);
        ack_ch[cnt] = bus.wr_ack[1] ? 1 : 0;
        ack_t[cnt] = cyc;
        cnt++;
        if (cnt == 4) bus.wr_req = 2'b00;
      end
    end
    bus.wr_req = 2'b00;
    check("fair_count", cnt, 4);
    for (int k = 0; k < cnt; k++) begin
      check($sformatf("fair_ch%0d", k), ack_ch[k], k % 2);
      if (k > 0)
        check($sformatf("fair_gap%0d", k),
              ack_t[k] - ack_t[k-1], 3);
    end

    // abort coincident with FINISH of 5th packet write
    do_reset;
    do_write(0, 16'h3000, 20, got, n);
    tick;
    do_write(0, 16'h3001, 20, got, n);
    tick;
    pkt(0, 0);
    for (int i = 0; i < 4; i++) begin
      do_write(0, 16'h3100 + 16'(i), 20, got, n);
      tick;
    end
    check("abt_mid_used", 32'(bus.used[D:0]), 6);
    bus.wr_data[DW-1:0] = 16'h3104;
    bus.wr_req[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      got = bus.wr_ack[0];
    end
    bus.pkt_abort[0] = 1'b1;
    bus.wr_req[0] = 1'b0;
    tick;
    bus.pkt_abort[0] = 1'b0;
    check("abt_ack", 32'(got), 1);
    check("abt_used", 32'(bus.used[D:0]), 2);
    check("abt_empty", 32'(bus.empty[0]), 0);
    do_read(0, 20, got, d);
    check("abt_rd0", 32'(d), 32'h3000);
    tick;
    do_read(0, 20, got, d);
    check("abt_rd1", 32'(d), 32'h3001);
    tick;
    do_read(0, 8, got, d);
    check("abt_novalid", 32'(got), 0);
    check("abt_final_used", 32'(bus.used[D:0]), 0);

    // random traffic against model
    do_reset;
    for (int it = 0; it < 250; it++) begin
      int c, r;
      c = int'($urandom_range(0, NCH - 1));
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        wr_chk($sformatf("rnd%0d_w", it), c, 16'($urandom));
        tick;
      end else if (r <= 6) begin
        rd_chk($sformatf("rnd%0d_r", it), c);
        tick;
      end else begin
        pkt(r - 7, c);
      end
      for (int k = 0; k < NCH; k++)
        chk_state($sformatf("rnd%0d_c%0d", it, k), k);
    end

    // reset during write strobe
    do_reset;
    do_write(0, 16'h4000, 20, got, n);
    tick;
    do_write(0, 16'h4001, 20, got, n);
    tick;
    bus.wr_data[DW-1:0] = 16'h4002;
    bus.wr_req[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick;
      got = !bus.WE_n;
    end
    check("rst_strobe_seen", 32'(got), 1);
    rst_n = 1'b0;
    #1;
    check("rst_we_n", 32'(bus.WE_n), 1);
    check("rst_ce_n", 32'(bus.CE_n), 1);
    check("rst_oe", 32'(bus.dq_oe), 0);
    check("rst_mid_used", 32'(bus.used), 0);
    bus.wr_req = '0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    check("rst_after_used", 32'(bus.used), 0);
    check("rst_after_empty", 32'(bus.empty), 32'h3);
    check("rst_after_full", 32'(bus.full), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
